// File: rtl/pipe_stage_ctrl_pkg.sv
// Shared types and helpers for the pipeline stage controller.
package pipe_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    // Width needed to count 0..stages valid entries.
    function automatic int occ_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_ctrl_vld.sv
// One pipeline stage valid bit with its leave/room handshake terms.
// room_in is the room of the next stage downstream (OUT_READY for the last stage).
module pipe_stage_ctrl_vld (
    input  logic CLK,
    input  logic RSTN,
    input  logic load,
    input  logic hold,
    input  logic room_in,
    input  logic clr,
    output logic vld,
    output logic leave,
    output logic room
);

    // An empty stage always has room, which is what collapses bubbles.
    assign leave = vld & ~hold & room_in;
    assign room  = ~vld | leave;

    // Valid bit: load wins, otherwise keep the item until it leaves.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            vld <= 1'b0;
        end else if (clr) begin
            vld <= 1'b0;
        end else begin
            vld <= load | (vld & ~leave);
        end
    end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Valid/enable/clear controller for a linear chain of pipeline registers.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_INIT  | one cycle after reset, all stage registers cleared
//   ST_RUN   | normal operation, intake open
//   ST_DRAIN | intake closed, items keep flowing out until the pipe is empty
//   ST_HALT  | pipe empty and intake closed until DRAIN_REQ drops
module pipe_stage_ctrl
    import pipe_stage_ctrl_pkg::*;
#(
    parameter int STAGES = 4,
    parameter int CNTW   = occ_width(STAGES)
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    input  logic [STAGES-1:0] HOLD,
    input  logic              FLUSH,
    input  logic              DRAIN_REQ,
    output logic [STAGES-1:0] STAGE_EN,
    output logic [STAGES-1:0] STAGE_CLR,
    output logic [STAGES-1:0] STAGE_VALID,
    output logic [CNTW-1:0]   OCC,
    output logic              HALTED
);

    state_t            state_q;
    state_t            state_d;
    logic              in_init;
    logic              clr_all;
    logic [STAGES-1:0] v;

    // Per-stage valid flops. The room chain is kept as per-block scalars so the
    // combinational ripple from OUT_READY back to IN_READY has no vector self-loop.
    for (genvar i = 0; i < STAGES; i++) begin : g
        logic room_in;
        logic leave;
        logic room;

        if (i == STAGES - 1) begin : g_tail
            assign room_in = OUT_READY;
        end else begin : g_body
            assign room_in = g[i+1].room;
        end

        if (i == 0) begin : g_head
            assign STAGE_EN[0] = IN_VALID & IN_READY;
        end else begin : g_link
            assign STAGE_EN[i] = g[i-1].leave & ~clr_all;
        end

        pipe_stage_ctrl_vld u_vld (
            .CLK     (CLK),
            .RSTN    (RSTN),
            .load    (STAGE_EN[i]),
            .hold    (HOLD[i]),
            .room_in (room_in),
            .clr     (clr_all),
            .vld     (v[i]),
            .leave   (leave),
            .room    (room)
        );
    end

    assign STAGE_VALID = v;

    // State register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; FLUSH only freezes HALT, RUN and DRAIN follow DRAIN_REQ/OCC.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  state_d = ST_RUN;
            ST_RUN:   if (DRAIN_REQ) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (OCC == '0) begin
                    state_d = ST_HALT;
                end else if (!DRAIN_REQ) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT:  if (!DRAIN_REQ && !FLUSH) state_d = ST_RUN;
            default:  state_d = ST_INIT;
        endcase
    end

    // End handshakes and clear controls.
    always_comb begin
        in_init   = (state_q == ST_INIT);
        clr_all   = in_init | FLUSH;
        STAGE_CLR = {STAGES{clr_all}};
        IN_READY  = g[0].room & (state_q == ST_RUN) & ~FLUSH;
        OUT_VALID = v[STAGES-1] & ~HOLD[STAGES-1] & ~clr_all;
        HALTED    = (state_q == ST_HALT);
    end

    // Occupancy: popcount of the registered valid bits.
    always_comb begin
        OCC = '0;
        for (int i = 0; i < STAGES; i++) begin
            OCC = OCC + CNTW'(v[i]);
        end
    end

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Randomized bench: slot-array reference model plus a data scoreboard fed by a
// bench-side datapath driven from STAGE_EN/STAGE_CLR.
module tb_pipe_stage_ctrl;

    localparam int S = 4;
    localparam int CW = $clog2(S + 1);

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic [S-1:0]  HOLD = '0;
    logic          FLUSH = 1'b0;
    logic          DRAIN_REQ = 1'b0;
    logic [S-1:0]  STAGE_EN;
    logic [S-1:0]  STAGE_CLR;
    logic [S-1:0]  STAGE_VALID;
    logic [CW-1:0] OCC;
    logic          HALTED;
    logic [15:0]   in_data = '0;

    pipe_stage_ctrl #(.STAGES(S)) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .HOLD        (HOLD),
        .FLUSH       (FLUSH),
        .DRAIN_REQ   (DRAIN_REQ),
        .STAGE_EN    (STAGE_EN),
        .STAGE_CLR   (STAGE_CLR),
        .STAGE_VALID (STAGE_VALID),
        .OCC         (OCC),
        .HALTED      (HALTED)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Bench-side data registers, controlled only by the DUT enables/clears.
    logic [15:0] dp [S];
    always @(posedge CLK) begin
        for (int i = 0; i < S; i++) begin
            if (STAGE_CLR[i])      dp[i] <= '0;
            else if (STAGE_EN[i])  dp[i] <= (i == 0) ? in_data : dp[i-1];
        end
    end

    logic [15:0] sb [$];

    // Reference model: mode 0=init 1=run 2=drain 3=halt; one bit per slot.
    int       mst = 0, nst = 0;
    bit [S-1:0] mv = '0, nv = '0, p_en = '0;
    bit       p_rdy, p_outv, p_clr, p_halt;
    int       p_occ;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_eval();
        bit [S-1:0] moves;
        bit free;
        p_occ = 0;
        for (int i = 0; i < S; i++) p_occ += int'(mv[i]);
        p_halt = (mst == 3);
        p_en   = '0;
        moves  = '0;
        if (mst == 0 || FLUSH) begin
            p_clr = 1; p_rdy = 0; p_outv = 0; nv = '0;
        end else begin
            p_clr = 0;
            // Walk from the output back: an item advances if the slot ahead
            // is, or is about to become, free.
            free = OUT_READY;
            for (int i = S - 1; i >= 0; i--) begin
                moves[i] = mv[i] && !HOLD[i] && free;
                free     = !mv[i] || moves[i];
            end
            p_outv  = mv[S-1] && !HOLD[S-1];
            p_rdy   = free && (mst == 1);
            p_en[0] = IN_VALID && p_rdy;
            for (int i = 1; i < S; i++) p_en[i] = moves[i-1];
            for (int i = 0; i < S; i++) nv[i] = p_en[i] || (mv[i] && !moves[i]);
        end
        case (mst)
            0: nst = 1;
            1: nst = DRAIN_REQ ? 2 : 1;
            2: nst = (p_occ == 0) ? 3 : (DRAIN_REQ ? 2 : 1);
            default: nst = (!DRAIN_REQ && !FLUSH) ? 1 : 3;
        endcase
    endtask

    // One clock: called at a falling edge, returns at the next falling edge.
    task automatic cycle(input bit iv, input bit ordy, input bit [S-1:0] hold,
                         input bit fl, input bit dr);
        IN_VALID  = iv;
        OUT_READY = ordy;
        HOLD      = hold;
        FLUSH     = fl;
        DRAIN_REQ = dr;
        in_data   = 16'($urandom);
        #1;
        model_eval();
        chk("in_ready",    32'(IN_READY),    32'(p_rdy));
        chk("out_valid",   32'(OUT_VALID),   32'(p_outv));
        chk("stage_en",    32'(STAGE_EN),    32'(p_en));
        chk("stage_clr",   32'(STAGE_CLR),   p_clr ? 32'hF : 32'h0);
        chk("stage_valid", 32'(STAGE_VALID), 32'(mv));
        chk("occ",         32'(OCC),         32'(p_occ));
        chk("halted",      32'(HALTED),      32'(p_halt));
        if (p_en[0]) sb.push_back(in_data);
        if (fl) sb.delete();
        @(posedge CLK);
        mv  = nv;
        mst = nst;
        cyc++;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        #1;
        chk("rst_stage_valid", 32'(STAGE_VALID), 0);
        chk("rst_occ",         32'(OCC),         0);
        chk("rst_out_valid",   32'(OUT_VALID),   0);
        chk("rst_in_ready",    32'(IN_READY),    0);
        chk("rst_stage_en",    32'(STAGE_EN),    0);
        chk("rst_stage_clr",   32'(STAGE_CLR),   32'hF);
        chk("rst_halted",      32'(HALTED),      0);
        mst = 0;
        mv  = '0;
        sb.delete();
        @(negedge CLK);
        RSTN = 1'b1;
    endtask

    // Monitor: pop and compare whenever the DUT hands an item downstream.
    always begin
        @(negedge CLK);
        #3;
        if (RSTN && OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL sb_underflow cyc=%0d got=%0h exp=none", cyc, dp[S-1]);
            end else begin
                chk("out_data", 32'(dp[S-1]), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        bit dr;
        @(negedge CLK);
        do_reset();

        // Streaming at full rate.
        repeat (20) cycle(1, 1, '0, 0, 0);
        // Back-pressure until full, then release.
        repeat (8) cycle(1, 0, '0, 0, 0);
        repeat (4) cycle(1, 1, '0, 0, 0);
        // Hold stage 1 with an emptied tail.
        repeat (6) cycle(0, 1, '0, 0, 0);
        repeat (2) cycle(1, 1, '0, 0, 0);
        repeat (3) cycle(1, 1, 4'b0010, 0, 0);
        repeat (8) cycle(1, 1, '0, 0, 0);
        // Flush with three items and a valid input.
        repeat (6) cycle(0, 1, '0, 0, 0);
        repeat (3) cycle(1, 0, '0, 0, 0);
        cycle(1, 1, '0, 1, 0);
        repeat (3) cycle(1, 1, '0, 0, 0);
        // Drain a full pipe, halt, then resume.
        repeat (5) cycle(1, 0, '0, 0, 0);
        repeat (8) cycle(1, 1, '0, 0, 1);
        repeat (6) cycle(1, 1, '0, 0, 0);
        // Flush and drain request together in RUN.
        cycle(1, 1, '0, 1, 1);
        repeat (3) cycle(1, 1, '0, 0, 1);
        repeat (3) cycle(1, 1, '0, 0, 0);
        // Reset mid-stream with two items in flight.
        repeat (6) cycle(0, 1, '0, 0, 0);
        repeat (2) cycle(1, 0, '0, 0, 0);
        do_reset();
        repeat (8) cycle(1, 1, '0, 0, 0);

        // Randomized traffic.
        dr = 0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 39) == 0) dr = ~dr;
            cycle($urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0,
                  S'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 0),
                  $urandom_range(0, 47) == 0,
                  dr);
        end

        // Let everything out and confirm nothing was lost.
        repeat (12) cycle(0, 1, '0, 0, 0);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
